// File: rtl/jt08_adpcm_ram_arb_if.sv
// jt08_adpcm_ram_arb_if: shared-memory req/ack port.
// Signals: req (held until ack), we, addr[AW-1:0], wdata[7:0] from the arbiter;
//          rdata[7:0] (valid with ack), ack (one-clk completion pulse) from memory.
// Modports: master = arbiter side, slave = memory side.
interface jt08_adpcm_ram_arb_if #(parameter int AW = 18);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic          ack;
    modport master(output req, we, addr, wdata, input rdata, ack);
    modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/jt08_adpcm_ram_arb.sv
// jt08_adpcm_ram_arb: arbitrates the ADPCM-B driver strobes and the FDD DMA requester onto one shared memory port.
// Ports: clk, rst (async, active high), cen (driver clock enable);
//        ADPCM: a_addr, a_dout, a_oe_n, a_wr_n in; a_din (held read data), a_busy out;
//        FDD:   f_req, f_we, f_addr, f_wdata in; f_rdata, f_ack (one-clk pulse) out;
//        mem:   jt08_adpcm_ram_arb_if.master shared-memory port;
//        late:  sticky flag, an ADPCM read missed the driver's read window.
// Optional: define JT08_ADPCM_ARB_LATE_EN to build the late-read counter; otherwise late is tied to 0.
module jt08_adpcm_ram_arb #(
    parameter int AW         = 18,
    parameter int LATE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic [23:0]           a_addr,
    input  logic [7:0]            a_dout,
    input  logic                  a_oe_n,
    input  logic                  a_wr_n,
    output logic [7:0]            a_din,
    output logic                  a_busy,
    input  logic                  f_req,
    input  logic                  f_we,
    input  logic [AW-1:0]         f_addr,
    input  logic [7:0]            f_wdata,
    output logic [7:0]            f_rdata,
    output logic                  f_ack,
    jt08_adpcm_ram_arb_if.master  mem,
    output logic                  late
);
    typedef enum logic [1:0] {IDLE, A_ACC, F_ACC, DONE} state_t;
    state_t        st;
    logic          oe_l, wr_l, a_pend, p_we;
    logic [AW-1:0] p_addr;
    logic [7:0]    p_dout;
    logic          rd_fall, wr_fall, issue_a, take;
    logic          unused;

    assign unused  = ^{cen, a_addr[23:AW]};
    assign rd_fall = oe_l & ~a_oe_n;
    assign wr_fall = wr_l & ~a_wr_n;
    // The latched request is being issued this clk, so a new edge would be lost on ack.
    assign issue_a = (st == IDLE) && a_pend && !f_req;
    assign take    = (rd_fall || wr_fall) && (st != A_ACC) && !issue_a;
    assign a_busy  = a_pend | (st == A_ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            oe_l      <= 1'b1;
            wr_l      <= 1'b1;
            a_pend    <= 1'b0;
            p_we      <= 1'b0;
            p_addr    <= '0;
            p_dout    <= '0;
            a_din     <= '0;
            f_rdata   <= '0;
            f_ack     <= 1'b0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
        end else begin
            oe_l  <= a_oe_n;
            wr_l  <= a_wr_n;
            f_ack <= 1'b0;
            if (take) begin
                a_pend <= 1'b1;
                p_addr <= a_addr[AW-1:0];
                p_we   <= wr_fall;
                p_dout <= a_dout;
            end
            case (st)
                IDLE:
                    if (f_req) begin
                        mem.req   <= 1'b1;
                        mem.we    <= f_we;
                        mem.addr  <= f_addr;
                        mem.wdata <= f_wdata;
                        st        <= F_ACC;
                    end else if (a_pend) begin
                        mem.req   <= 1'b1;
                        mem.we    <= p_we;
                        mem.addr  <= p_addr;
                        mem.wdata <= p_dout;
                        st        <= A_ACC;
                    end
                A_ACC:
                    if (mem.ack) begin
                        mem.req <= 1'b0;
                        if (!p_we) a_din <= mem.rdata;
                        a_pend  <= 1'b0;
                        st      <= DONE;
                    end
                F_ACC:
                    if (mem.ack) begin
                        mem.req <= 1'b0;
                        f_rdata <= mem.rdata;
                        f_ack   <= 1'b1;
                        st      <= DONE;
                    end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef JT08_ADPCM_ARB_LATE_EN
    logic [2:0] cnt;
    logic       rd_act;
    assign rd_act = a_pend & ~p_we;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            late <= 1'b0;
        end else begin
            if (take && !wr_fall) cnt <= '0;
            else if (cen && rd_act && cnt != 3'd7) cnt <= cnt + 3'd1;
            if (rd_act && cnt >= 3'(LATE_LIMIT) && !(st == A_ACC && mem.ack)) late <= 1'b1;
        end
    end
`else
    assign late = 1'b0;
`endif
endmodule

// File: tb/tb_jt08_adpcm_ram_arb.sv
// tb_jt08_adpcm_ram_arb: directed, table-driven bench for jt08_adpcm_ram_arb (AW=18).
module tb_jt08_adpcm_ram_arb;
`ifdef JT08_ADPCM_ARB_LATE_EN
    localparam logic LATE_EXP = 1'b1;
`else
    localparam logic LATE_EXP = 1'b0;
`endif
    logic        clk = 0, rst = 1, cen = 1;
    logic [23:0] a_addr = '0;
    logic [7:0]  a_dout = '0, a_din, f_wdata = '0, f_rdata;
    logic        a_oe_n = 1, a_wr_n = 1, a_busy, f_req = 0, f_we = 0, f_ack, late;
    logic [17:0] f_addr = '0;
    int          pass = 0, total = 0, fack_n = 0, fack0, cyc;

    jt08_adpcm_ram_arb_if #(.AW(18)) mem();

    jt08_adpcm_ram_arb #(.AW(18), .LATE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .a_addr(a_addr), .a_dout(a_dout), .a_oe_n(a_oe_n), .a_wr_n(a_wr_n),
        .a_din(a_din), .a_busy(a_busy),
        .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
        .f_rdata(f_rdata), .f_ack(f_ack),
        .mem(mem.master), .late(late)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (f_ack) fack_n++;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  dout;
        logic        wr;
        logic [7:0]  rdata;
        logic [17:0] eaddr;
        logic [7:0]  edin;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass++;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem.req && n < 20);
        chk("req_timeout", mem.req, 1);
    endtask

    task automatic ack_pulse(input logic [7:0] d);
        mem.rdata = d;
        mem.ack   = 1;
        @(negedge clk);
        mem.ack   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem.ack = 0;
        mem.rdata = '0;
        vt[0] = '{24'h001234, 8'h00, 1'b0, 8'hA5, 18'h01234, 8'hA5};
        vt[1] = '{24'h000010, 8'h3C, 1'b1, 8'h77, 18'h00010, 8'hA5};
        vt[2] = '{24'hFC0055, 8'h00, 1'b0, 8'h5A, 18'h00055, 8'h5A};
        vt[3] = '{24'h03FFFF, 8'h00, 1'b0, 8'hFF, 18'h3FFFF, 8'hFF};
        vt[4] = '{24'hABCDEF, 8'h81, 1'b1, 8'h00, 18'h3CDEF, 8'hFF};

        repeat (2) @(negedge clk);
        chk("rst_req", mem.req, 0);
        chk("rst_din", a_din, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_fack", f_ack, 0);
        chk("rst_late", late, 0);
        rst = 0;
        @(negedge clk);
        ack_pulse(8'h5F);
        chk("stray_req", mem.req, 0);
        chk("stray_din", a_din, 0);
        @(negedge clk);
        chk("stray_req2", mem.req, 0);
        chk("stray_busy", a_busy, 0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_addr = vt[i].addr;
            a_dout = vt[i].dout;
            if (vt[i].wr) a_wr_n = 0;
            else a_oe_n = 0;
            wait_req(cyc);
            chk($sformatf("v%0d_latency", i), cyc, 2);
            chk($sformatf("v%0d_addr", i), mem.addr, vt[i].eaddr);
            chk($sformatf("v%0d_we", i), mem.we, vt[i].wr);
            if (vt[i].wr) chk($sformatf("v%0d_wdata", i), mem.wdata, vt[i].dout);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_hold", i), mem.req, 1);
            ack_pulse(vt[i].rdata);
            chk($sformatf("v%0d_req_drop", i), mem.req, 0);
            chk($sformatf("v%0d_din", i), a_din, vt[i].edin);
            chk($sformatf("v%0d_busy", i), a_busy, 0);
            a_oe_n = 1;
            a_wr_n = 1;
            @(negedge clk);
        end
        chk("uncontended_late", late, 0);

        // FDD and ADPCM read in the same clk: FDD first, then ADPCM after the DONE gap.
        @(negedge clk);
        fack0  = fack_n;
        f_addr = 18'h20000;
        f_we   = 0;
        f_req  = 1;
        a_addr = 24'h000300;
        a_oe_n = 0;
        @(negedge clk);
        chk("sim_f_req", mem.req, 1);
        chk("sim_f_addr", mem.addr, 18'h20000);
        chk("sim_f_we", mem.we, 0);
        chk("sim_busy", a_busy, 1);
        a_oe_n = 1;
        ack_pulse(8'h42);
        chk("sim_fack", f_ack, 1);
        chk("sim_frdata", f_rdata, 8'h42);
        chk("sim_req_low", mem.req, 0);
        f_req = 0;
        @(negedge clk);
        chk("sim_gap", mem.req, 0);
        wait_req(cyc);
        chk("sim_a_cyc", cyc, 1);
        chk("sim_a_addr", mem.addr, 18'h00300);
        ack_pulse(8'h99);
        chk("sim_a_din", a_din, 8'h99);
        chk("sim_a_busy", a_busy, 0);
        @(negedge clk);
        #1 chk("sim_fack_count", fack_n - fack0, 1);

        // Two read edges while FDD is in flight: only the second address is issued.
        @(negedge clk);
        f_addr = 18'h00400;
        f_req  = 1;
        @(negedge clk);
        a_addr = 24'h000100;
        a_oe_n = 0;
        @(negedge clk);
        a_oe_n = 1;
        @(negedge clk);
        a_addr = 24'h000200;
        a_oe_n = 0;
        @(negedge clk);
        a_oe_n = 1;
        ack_pulse(8'h10);
        f_req = 0;
        wait_req(cyc);
        chk("ovw_addr", mem.addr, 18'h00200);
        ack_pulse(8'h3E);
        chk("ovw_din", a_din, 8'h3E);
        repeat (4) @(negedge clk);
        chk("ovw_no_reissue", mem.req, 0);
        chk("ovw_busy", a_busy, 0);

        // ADPCM read stuck behind a long FDD access.
        @(negedge clk);
        f_addr = 18'h00008;
        f_req  = 1;
        a_addr = 24'h000500;
        a_oe_n = 0;
        wait_req(cyc);
        repeat (8) @(negedge clk);
        a_oe_n = 1;
        chk("late_mid", late, LATE_EXP);
        ack_pulse(8'h11);
        f_req = 0;
        wait_req(cyc);
        chk("late_a_addr", mem.addr, 18'h00500);
        ack_pulse(8'h22);
        chk("late_a_din", a_din, 8'h22);
        repeat (3) @(negedge clk);
        chk("late_sticky", late, LATE_EXP);

        // Reset during an ADPCM access, then a stray ack.
        a_addr = 24'h000777;
        a_oe_n = 0;
        wait_req(cyc);
        rst    = 1;
        a_oe_n = 1;
        #1;
        chk("mid_rst_req", mem.req, 0);
        chk("mid_rst_din", a_din, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_late", late, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        ack_pulse(8'hEE);
        chk("mid_stray_req", mem.req, 0);
        chk("mid_stray_din", a_din, 0);
        repeat (3) @(negedge clk);
        chk("mid_stray_req2", mem.req, 0);
        chk("mid_stray_busy", a_busy, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/jt08_adpcm_ram_arb.md
Name: jt08_adpcm_ram_arb

Overview:
- Shared-memory arbiter directly downstream of the ADPCM-B driver's external-RAM strobe interface.
- Converts the driver's strobes (addr, oe_n, wr_n, dout) into req/ack transactions on a single shared memory port, which it also grants to the FDD DMA requester.
- Holds read data stable for the driver's fixed-wait sampling.
- Reports accesses that were not served within the driver's read window.

Parameters:
AW, 18, shared-memory address width; driver address bits above AW-1 are ignored.
LATE_LIMIT, 4, number of cen cycles from read strobe to ack before an access counts as late. Matches the driver's read wait.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cen  in  1  8 MHz clock enable (the driver's cen)
a_addr  in  24  driver address
a_dout  in  8  driver write data
a_oe_n  in  1  driver read strobe, active low
a_wr_n  in  1  driver write strobe, active low
a_din  out  8  read data returned to driver, held until next ADPCM read completes
a_busy  out  1  ADPCM access pending or in flight
f_req  in  1  FDD request, level; held until f_ack
f_we  in  1  FDD write
f_addr  in  AW  FDD address
f_wdata  in  8  FDD write data
f_rdata  out  8  FDD read data, valid with f_ack
f_ack  out  1  one-clk pulse when FDD access completes
mem_req  out  1  shared-memory request, held until mem_ack
mem_we  out  1  write qualifier
mem_addr  out  AW  address
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  one-clk completion pulse
late  out  1  sticky: an ADPCM read exceeded LATE_LIMIT

Behaviour:
- Reset (async): all outputs 0, the FSM goes to IDLE, pending flags clear, a_din=0.
- A mem_ack arriving after reset while no request is outstanding is ignored.
- Strobe capture:
  - a_oe_n and a_wr_n are sampled every clk.
  - A falling edge sets a_pend and latches a_addr[AW-1:0], the type (write when a_wr_n fell), and a_dout.
  - If both strobes fall in the same clk, the write wins.
  - A new falling edge while a_pend is set and not yet issued overwrites the latched request.
  - A falling edge while an ADPCM access is in flight is dropped.
- FSM states: IDLE, A_ACC, F_ACC, DONE.
  - IDLE: if f_req and a_pend are both set, FDD is served first. FDD is also served when only f_req is set.
  - IDLE: go to A_ACC when only a_pend is set.
  - On entry to A_ACC or F_ACC: mem_req=1 with the latched address, we and data.
  - A_ACC/F_ACC: stay until mem_ack.
  - On mem_ack in A_ACC: drop mem_req; on a read, a_din<=mem_rdata; clear a_pend.
  - On mem_ack in F_ACC: drop mem_req; f_rdata<=mem_rdata; f_ack pulses for one clk.
  - Then go to DONE.
  - DONE: one idle clk, so mem_req is low for at least one clk between transactions. Then return to IDLE.
- No preemption: an access in flight always completes.
  - If a_oe_n rises before mem_ack, the read still completes and a_din updates.
- a_busy = a_pend OR (state==A_ACC).
- Latency: an uncontended ADPCM read issues mem_req 2 clk after the a_oe_n falling edge (1 clk edge detect, 1 clk IDLE decision).
- Address truncation: mem_addr = latched a_addr[AW-1:0]; upper bits have no effect.

Optional Feature:
Macro JT08_ADPCM_ARB_LATE_EN.
- Defined:
  - A 3-bit saturating counter resets on each ADPCM read edge and increments on cen while that read is pending or in flight.
  - If it reaches LATE_LIMIT before mem_ack, late is set and stays set until rst.
- Undefined: the counter is not built and late is tied to 0.

Test Plan:
- Uncontended read: a_addr=0x001234, a_oe_n falls, mem_ack returns 0xA5 after 3 clk -> mem_req rises 2 clk after the edge with mem_addr=0x01234 (AW=18, bits above 17 dropped), mem_we=0; a_din=0xA5 from the clk after mem_ack and held; a_busy low after ack.
- Write: a_dout=0x3C, a_wr_n falls at a_addr=0x000010 -> mem_we=1, mem_wdata=0x3C, mem_addr=0x00010; a_din unchanged.
- Simultaneous requests: f_req with f_addr=0x20000 and an ADPCM read in the same clk -> FDD served first, f_ack pulses once; after DONE, ADPCM served; mem_req low for at least 1 clk between transactions.
- Late read with the macro defined: FDD access held 8 cen cycles while an ADPCM read is pending -> late=1 and stays 1. Same stimulus without the macro -> late=0.
- Reset mid-access: rst asserted while A_ACC is active, then mem_ack pulses -> mem_req=0 immediately, a_din=0, no state change from the stray ack.
- Strobe overwrite: two read edges at 0x100 then 0x200 while FDD is in flight -> only 0x200 is issued.
